fp_normalize_round: RTL and testbench

Pipelined post-add normalization and rounding stage for the floating-point adder datapath. Takes the raw, unnormalized sum from the significand add/subtract stage (sign, effective exponent, extended significand with guard/round/sticky) and produces a packed `floating_point_number_t` result, rounded to nearest-even, with inexact/overflow flags. Two register stages, valid/ready handshake on both sides, throughput one result per cycle.

---
 rtl/fp_normalize_round_pkg.sv | 24 ++
 rtl/fp_lzc.sv | 19 +
 rtl/fp_normalize_round.sv | 137 +++++++++++++
 tb/tb_fp_normalize_round.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_normalize_round_pkg.sv
// rtl/fp_normalize_round_pkg.sv - shared floating-point widths, types and constants
package fp_normalize_round_pkg;

  localparam int exp_width = 11;
  localparam int sig_width = 52;
  localparam int exp_bias  = 1023;

  typedef struct packed {
    logic                 sign;
    logic [exp_width-1:0] exp;
    logic [sig_width-1:0] frac;
  } floating_point_number_t;

  // Unnormalized sum from the significand adder: carry, hidden, fraction, G, R, S
  typedef struct packed {
    logic                 sign;
    logic [exp_width:0]   exp;
    logic [sig_width+4:0] mant;
  } raw_sum_t;

  localparam floating_point_number_t canonical_qnan =
    floating_point_number_t'({1'b0, {exp_width{1'b1}}, 1'b1, {(sig_width-1){1'b0}}});

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter
module fp_lzc #(
  parameter int W = 56
) (
  input  logic [W-1:0]           value,
  output logic [$clog2(W+1)-1:0] count
);

  localparam int CW = $clog2(W+1);

  // Scan upward so the highest set bit has the final say; all-zero yields W
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (value[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - two-stage post-add normalize and round-to-nearest-even
module fp_normalize_round
  import fp_normalize_round_pkg::*;
#(
  parameter int EXP_W = exp_width,
  parameter int SIG_W = sig_width
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W:0]         in_exp,
  input  logic [SIG_W+4:0]       in_mant,
  input  logic                   in_nan,
  input  logic                   in_inf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output floating_point_number_t out_result,
  output logic                   out_inexact,
  output logic                   out_overflow
);

  localparam int MW = SIG_W + 4;          // hidden..sticky, carry excluded
  localparam int CW = $clog2(MW + 1);
  localparam int XW = EXP_W + 2;          // wide enough that exp+1 and rounding never wrap

  raw_sum_t raw;
  assign raw = {in_sign, in_exp, in_mant};

  logic [MW-1:0] low;
  logic [CW-1:0] lz;
  assign low = raw.mant[MW-1:0];

  fp_lzc #(.W(MW)) u_lzc (
    .value (low),
    .count (lz)
  );

  logic [XW-1:0] exp_ext, exp_m1, lz_ext, shamt, n_exp;
  logic [MW-1:0] n_mant;

  // Normalize: right-shift on carry-out, else left-shift limited so exponent stays >= 1
  always_comb begin
    exp_ext = {1'b0, raw.exp};
    exp_m1  = exp_ext - XW'(1);
    lz_ext  = XW'(lz);
    shamt   = (lz_ext < exp_m1) ? lz_ext : exp_m1;
    if (raw.mant[MW]) begin
      n_mant = {raw.mant[MW:2], raw.mant[1] | raw.mant[0]};
      n_exp  = exp_ext + XW'(1);
    end else begin
      n_mant = low << shamt;
      n_exp  = exp_ext - shamt;
    end
    // No hidden bit left means subnormal or zero, which encode exponent 0
    if (!n_mant[MW-1]) n_exp = '0;
  end

  logic s2_adv;
  logic s1_valid, s1_sign, s1_g, s1_rs, s1_nan, s1_inf;
  logic [XW-1:0]    s1_exp;
  logic [SIG_W-1:0] s1_frac;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // Stage 1 register: loads whenever the slot is free or draining this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_g     <= 1'b0;
      s1_rs    <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= raw.sign;
        s1_exp  <= n_exp;
        s1_frac <= n_mant[MW-2:3];
        s1_g    <= n_mant[2];
        s1_rs   <= n_mant[1] | n_mant[0];
        s1_nan  <= in_nan;
        s1_inf  <= in_inf;
      end
    end
  end

  logic                   inc, r_ovf, r_inexact;
  logic [XW+SIG_W-1:0]    rounded;
  logic [XW-1:0]          r_exp;
  floating_point_number_t r_result;

  // Round: adding into {exp, frac} lets a fraction carry bump the exponent,
  // including the subnormal-to-smallest-normal case
  always_comb begin
    inc       = s1_g & (s1_rs | s1_frac[0]);
    rounded   = {s1_exp, s1_frac} + (XW+SIG_W)'(inc);
    r_exp     = rounded[XW+SIG_W-1:SIG_W];
    r_ovf     = 1'b0;
    r_inexact = s1_g | s1_rs;
    r_result  = {s1_sign, r_exp[EXP_W-1:0], rounded[SIG_W-1:0]};
    if (s1_nan) begin
      r_result  = canonical_qnan;
      r_inexact = 1'b0;
    end else if (s1_inf) begin
      r_result  = {s1_sign, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
      r_inexact = 1'b0;
    end else if (r_exp >= {2'b00, {EXP_W{1'b1}}}) begin
      r_result  = {s1_sign, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
      r_ovf     = 1'b1;
      r_inexact = 1'b1;
    end
  end

  // Stage 2 / output register: held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result   <= r_result;
        out_inexact  <= r_inexact;
        out_overflow <= r_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb/tb_fp_normalize_round.sv - scoreboard bench for fp_normalize_round
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_nan, in_inf;
  logic [11:0] in_exp;
  logic [56:0] in_mant;
  logic        out_valid, out_ready, out_inexact, out_overflow;
  logic [63:0] out_result;

  fp_normalize_round dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .in_nan       (in_nan),
    .in_inf       (in_inf),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_inexact  (out_inexact),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        inex;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [51:0] ONES = {52{1'b1}};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [56:0] mk(input logic c, input logic h, input logic [51:0] f,
                                     input logic g, input logic r, input logic s);
    return {c, h, f, g, r, s};
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge
  task automatic send(input logic sgn, input logic [11:0] e, input logic [56:0] m,
                      input logic nan, input logic inf,
                      input logic [63:0] er, input logic ei, input logic eo);
    exp_t item;
    in_valid = 1'b1;
    in_sign  = sgn;
    in_exp   = e;
    in_mant  = m;
    in_nan   = nan;
    in_inf   = inf;
    #1;
    for (int k = 0; k < 100 && !in_ready; k++) begin
      @(negedge clk);
      #1;
    end
    check("send_accept", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    item.res  = er;
    item.inex = ei;
    item.ovf  = eo;
    sbq.push_back(item);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sbq.size() != 0; k++) @(negedge clk);
    check("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  logic        held = 1'b0;
  logic [63:0] held_res;
  logic        held_inex, held_ovf;

  // Output monitor: samples mid-low-phase, after the driver has settled
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_result", out_result, held_res);
        check("stall_flags", {62'd0, out_inexact, out_overflow}, {62'd0, held_inex, held_ovf});
      end
      if (out_valid && out_ready) begin
        tests++;
        assert (sbq.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_output observed=%h expected=no output", out_result);
        end
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          check("result", out_result, e.res);
          check("inexact", {63'd0, out_inexact}, {63'd0, e.inex});
          check("overflow", {63'd0, out_overflow}, {63'd0, e.ovf});
        end
      end
      held      = out_valid && !out_ready;
      held_res  = out_result;
      held_inex = out_inexact;
      held_ovf  = out_overflow;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_nan    = 1'b0;
    in_inf    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_result", out_result, 64'd0);
    check("rst_flags", {62'd0, out_inexact, out_overflow}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values, streamed back to back
    send(0, 12'd1023, mk(1, 0, 52'h0, 0, 0, 0), 0, 0, 64'h4000000000000000, 0, 0);
    send(0, 12'd1023, mk(0, 0, 52'h8000000000000, 0, 0, 0), 0, 0, 64'h3FE0000000000000, 0, 0);
    send(0, 12'd1023, mk(0, 1, 52'h1, 1, 0, 0), 0, 0, 64'h3FF0000000000002, 1, 0);
    send(0, 12'd1023, mk(0, 1, 52'h2, 1, 0, 0), 0, 0, 64'h3FF0000000000002, 1, 0);
    send(0, 12'd2046, mk(1, 0, 52'h0, 0, 0, 0), 0, 0, 64'h7FF0000000000000, 1, 1);
    send(1, 12'd5, mk(1, 1, 52'h123, 1, 1, 1), 1, 1, 64'h7FF8000000000000, 0, 0);
    send(1, 12'd1023, mk(0, 1, 52'h7, 1, 1, 1), 0, 1, 64'hFFF0000000000000, 0, 0);
    send(1, 12'd5, mk(0, 0, 52'h0, 0, 0, 0), 0, 0, 64'h8000000000000000, 0, 0);
    send(0, 12'd1, mk(0, 0, 52'h8000000000000, 0, 0, 0), 0, 0, 64'h0008000000000000, 0, 0);
    send(0, 12'd1, mk(0, 0, ONES, 1, 1, 0), 0, 0, 64'h0010000000000000, 1, 0);
    send(0, 12'd1023, mk(1, 1, 52'h1, 0, 0, 0), 0, 0, 64'h4008000000000000, 1, 0);
    send(0, 12'd1023, mk(0, 1, ONES, 1, 0, 1), 0, 0, 64'h4000000000000000, 1, 0);
    send(0, 12'd2046, mk(0, 1, ONES, 1, 1, 0), 0, 0, 64'h7FF0000000000000, 1, 1);
    send(0, 12'd1023, mk(0, 0, 52'h1, 0, 0, 0), 0, 0, 64'h3CB0000000000000, 0, 0);
    send(0, 12'd1023, mk(0, 1, 52'h5, 0, 1, 1), 0, 0, 64'h3FF0000000000005, 1, 0);
    drain();

    // Backpressure: two items fill the pipe, then in_ready must stay low
    out_ready = 1'b0;
    send(0, 12'd1023, mk(0, 0, 52'h8000000000000, 0, 0, 0), 0, 0, 64'h3FE0000000000000, 0, 0);
    send(0, 12'd1023, mk(1, 0, 52'h0, 0, 0, 0), 0, 0, 64'h4000000000000000, 0, 0);
    for (int c = 0; c < 3; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    send(0, 12'd1023, mk(0, 1, 52'h1, 1, 0, 0), 0, 0, 64'h3FF0000000000002, 1, 0);
    send(0, 12'd1, mk(0, 0, 52'h8000000000000, 0, 0, 0), 0, 0, 64'h0008000000000000, 0, 0);
    drain();

    // Asynchronous reset with both stages occupied
    out_ready = 1'b0;
    send(0, 12'd1023, mk(1, 0, 52'h0, 0, 0, 0), 0, 0, 64'h4000000000000000, 0, 0);
    send(1, 12'd1023, mk(1, 0, 52'h0, 0, 0, 0), 0, 0, 64'hC000000000000000, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_result", out_result, 64'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("post_rst_idle", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    send(0, 12'd1023, mk(0, 1, 52'h2, 1, 0, 0), 0, 0, 64'h3FF0000000000002, 1, 0);
    #1;
    check("latency_not_yet", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    #1;
    check("latency_valid", {63'd0, out_valid}, 64'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
